emif_status_mon: RTL and testbench
==================================

EMIF_STATUS_MON -- requirements
Module: emif_status_mon

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of memory-controller channels monitored (legal range 1..8).
REQ-002 SHALL have parameter HB_BITS, default 26, heartbeat counter width.
REQ-003 SHALL have parameter BLINK_BIT, default 23, heartbeat bit used as fail-blink rate (must be < HB_BITS).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, flop stages on every asynchronous input (legal range >= 2).
REQ-005 SHALL have parameter DB_CYCLES, default 500000, push-button debounce length in clocks (10 ms at 50 MHz).
REQ-006 SHALL have port clk_50_max10, input, 1, system clock; all logic on rising edge.
REQ-007 SHALL have port fpga_resetn, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port init_done, input, NUM_CH, per-channel controller init complete; asynchronous.
REQ-009 SHALL have port cal_success, input, NUM_CH, per-channel calibration pass; asynchronous.
REQ-010 SHALL have port cal_fail, input, NUM_CH, per-channel calibration fail; asynchronous.
REQ-011 SHALL have port error_mon, input, NUM_CH, per-channel traffic-checker error; asynchronous.
REQ-012 SHALL have port pb_clr_n, input, 1, active-low push button that clears sticky errors; asynchronous, bouncy.
REQ-013 SHALL have port ch_sel, input, 3, selects the channel shown on LEDs 0..2; quasi-static DIP input.
REQ-014 SHALL have port user_led, output, 5, board LEDs, active-low (0 = lit).
REQ-015 SHALL have port sticky_err, output, NUM_CH, latched per-channel error flags.
REQ-016 SHALL have port all_ready, output, 1, high when every channel is in READY.

Function
REQ-017 SHALL pass init_done, cal_success, cal_fail, error_mon and pb_clr_n through SYNC_STAGES flops each; the ch_sel input is not synchronised.
REQ-018 SHALL run a free-running HB_BITS-bit heartbeat counter, +1 per clock, wrapping from all-ones to 0.
REQ-019 SHALL keep a per-channel FSM with states WAIT, CAL_OK, READY and FAIL, each transition evaluated on synchronised inputs.
REQ-020 SHALL apply these FSM transitions:
- WAIT->FAIL on cal_fail;
- WAIT->CAL_OK on cal_success;
- CAL_OK->READY on init_done;
- CAL_OK->WAIT and READY->WAIT when cal_success drops (recalibration);
- any state->FAIL on cal_fail.
REQ-021 SHALL give cal_fail priority when cal_fail and cal_success are high in the same cycle; FAIL SHALL be left only by reset.
REQ-022 SHALL give latency from an asynchronous input edge to the FSM state of SYNC_STAGES+1 clocks, and to user_led/all_ready one further clock.
REQ-023 SHALL set sticky_err[i] in any cycle where synchronised error_mon[i]=1 and hold it until a clear event.
REQ-024 SHALL debounce the button: debounced level (reset 1) SHALL take the synchronised value only after it differs from the debounced level for DB_CYCLES consecutive clocks; any agreeing cycle SHALL zero the counter.
REQ-025 SHALL make the clear event a one-clock pulse on the debounced 1->0 transition; the clear event SHALL zero all sticky_err bits, except that a simultaneous set wins for that bit.
REQ-026 SHALL drive user_led[0] lit when the selected channel is READY.
REQ-027 SHALL drive user_led[1] as follows for the selected channel:
- WAIT: off;
- CAL_OK or READY: steady lit;
- FAIL: heartbeat[BLINK_BIT] (blinking).
REQ-028 SHALL drive user_led[2] lit when sticky_err of the selected channel is set.
REQ-029 SHALL drive user_led[3] lit when any sticky_err bit is set.
REQ-030 SHALL drive user_led[4] as heartbeat[HB_BITS-1].
REQ-031 SHALL drive user_led[2:0] = 3'b111 (all off) when ch_sel >= NUM_CH; user_led[4:3] SHALL be unaffected.
REQ-032 SHALL register user_led and all_ready; sticky_err SHALL come directly from its latch flops.

Reset
REQ-033 SHALL, on fpga_resetn low, asynchronously set heartbeat=0, all FSMs=WAIT, sticky_err=0, debounced level=1, debounce counter=0, sync flops=0 except the pb_clr_n chain which resets to 1, user_led=5'b01111 and all_ready=0.
REQ-034 SHALL deassert reset synchronously externally, and SHALL abandon any in-progress debounce count at reset.

Verification
Bench parameters: NUM_CH=2, HB_BITS=8, BLINK_BIT=4, DB_CYCLES=4, SYNC_STAGES=2.
REQ-035 SHALL cover: reset held, then released -> user_led=5'b01111 and all_ready=0; user_led[4] toggles every 128 clocks.
REQ-036 SHALL cover: ch0 cal_success then init_done, ch_sel=0 -> READY 3 clocks after init_done, user_led[1:0]=2'b00 one clock later; all_ready=1 only after ch1 is also READY.
REQ-037 SHALL cover: ch1 cal_fail and cal_success pulsed in the same cycle, ch_sel=1 -> FAIL; user_led[1] toggles every 16 clocks; dropping cal_fail does not leave FAIL.
REQ-038 SHALL cover: error_mon[0] pulsed for 1 clock -> sticky_err=2'b01 and user_led[3]=0; pb_clr_n bouncing with a 3-clock low -> no clear; a 6-clock low -> sticky_err=0 within 2+4+1 clocks.
REQ-039 SHALL cover: error_mon[0] held high during the clear pulse -> sticky_err[0] stays 1.
REQ-040 SHALL cover: ch_sel=5 -> user_led[2:0]=3'b111; reset asserted mid-debounce -> all state returns to the REQ-033 values.

Source files
------------

// File: rtl/emif_status_mon.sv
// emif_status_mon
// Board-level status monitor for NUM_CH external-memory controller channels.
// Each channel's status lines are synchronised, fed to a small per-channel
// state machine (WAIT / CAL_OK / READY / FAIL), and summarised on five
// active-low LEDs. Traffic-checker errors are latched into sticky flags that
// are cleared by a debounced push button.
//
// Ports
//   clk_50_max10  in   system clock, rising edge
//   fpga_resetn   in   asynchronous active-low reset
//   init_done     in   [NUM_CH] controller init complete (async)
//   cal_success   in   [NUM_CH] calibration pass (async)
//   cal_fail      in   [NUM_CH] calibration fail (async)
//   error_mon     in   [NUM_CH] traffic-checker error (async)
//   pb_clr_n      in   active-low, bouncy clear button (async)
//   ch_sel        in   [3] channel shown on LEDs 0..2 (quasi-static)
//   user_led      out  [5] LEDs, 0 = lit
//   sticky_err    out  [NUM_CH] latched error flags
//   all_ready     out  every channel is READY
module emif_status_mon #(
    parameter int NUM_CH      = 2,
    parameter int HB_BITS     = 26,
    parameter int BLINK_BIT   = 23,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 500000
) (
    input  logic              clk_50_max10,
    input  logic              fpga_resetn,
    input  logic [NUM_CH-1:0] init_done,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    input  logic [NUM_CH-1:0] error_mon,
    input  logic              pb_clr_n,
    input  logic [2:0]        ch_sel,
    output logic [4:0]        user_led,
    output logic [NUM_CH-1:0] sticky_err,
    output logic              all_ready
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_CAL_OK = 2'd1,
        ST_READY  = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    localparam int                 DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_ONE  = DB_W'(1);
    localparam logic [HB_BITS-1:0] HB_ONE  = HB_BITS'(1);

    // ---------------- input synchronisers ----------------
    logic [NUM_CH-1:0] r_init_sync [SYNC_STAGES];
    logic [NUM_CH-1:0] r_cok_sync  [SYNC_STAGES];
    logic [NUM_CH-1:0] r_cfail_sync[SYNC_STAGES];
    logic [NUM_CH-1:0] r_err_sync  [SYNC_STAGES];
    logic              r_pb_sync   [SYNC_STAGES];

    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_init_sync[s]  <= '0;
                r_cok_sync[s]   <= '0;
                r_cfail_sync[s] <= '0;
                r_err_sync[s]   <= '0;
                r_pb_sync[s]    <= 1'b1;   // button idles released
            end
        end else begin
            r_init_sync[0]  <= init_done;
            r_cok_sync[0]   <= cal_success;
            r_cfail_sync[0] <= cal_fail;
            r_err_sync[0]   <= error_mon;
            r_pb_sync[0]    <= pb_clr_n;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_init_sync[s]  <= r_init_sync[s-1];
                r_cok_sync[s]   <= r_cok_sync[s-1];
                r_cfail_sync[s] <= r_cfail_sync[s-1];
                r_err_sync[s]   <= r_err_sync[s-1];
                r_pb_sync[s]    <= r_pb_sync[s-1];
            end
        end
    end

    logic [NUM_CH-1:0] w_init;
    logic [NUM_CH-1:0] w_cok;
    logic [NUM_CH-1:0] w_cfail;
    logic [NUM_CH-1:0] w_err;
    logic              w_pb;

    assign w_init  = r_init_sync[SYNC_STAGES-1];
    assign w_cok   = r_cok_sync[SYNC_STAGES-1];
    assign w_cfail = r_cfail_sync[SYNC_STAGES-1];
    assign w_err   = r_err_sync[SYNC_STAGES-1];
    assign w_pb    = r_pb_sync[SYNC_STAGES-1];

    // ---------------- heartbeat ----------------
    logic [HB_BITS-1:0] r_hb;

    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) r_hb <= '0;
        else              r_hb <= r_hb + HB_ONE;
    end

    // ---------------- per-channel state machines ----------------
    logic [NUM_CH-1:0] w_ready;
    logic [NUM_CH-1:0] w_lit;    // CAL_OK or READY: LED1 steady on
    logic [NUM_CH-1:0] w_fail;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t r_state;
            state_t w_state_next;

            always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
                if (!fpga_resetn) r_state <= ST_WAIT;
                else              r_state <= w_state_next;
            end

            // cal_fail is checked first so it wins over a coincident
            // cal_success; FAIL has no exit other than reset.
            always_comb begin
                w_state_next = r_state;
                if (w_cfail[gi]) begin
                    w_state_next = ST_FAIL;
                end else begin
                    case (r_state)
                        ST_WAIT:   if (w_cok[gi])  w_state_next = ST_CAL_OK;
                        ST_CAL_OK: begin
                            if (!w_cok[gi])        w_state_next = ST_WAIT;
                            else if (w_init[gi])   w_state_next = ST_READY;
                        end
                        ST_READY:  if (!w_cok[gi]) w_state_next = ST_WAIT;
                        default:                   w_state_next = ST_FAIL;
                    endcase
                end
            end

            assign w_ready[gi] = (r_state == ST_READY);
            assign w_lit[gi]   = (r_state == ST_CAL_OK) || (r_state == ST_READY);
            assign w_fail[gi]  = (r_state == ST_FAIL);
        end
    endgenerate

    // ---------------- push-button debounce ----------------
    logic            r_db_level;
    logic            r_db_prev;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_clr;

    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) begin
            r_db_level <= 1'b1;
            r_db_prev  <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_db_prev <= r_db_level;
            if (w_pb != r_db_level) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db_level <= w_pb;
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_ONE;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // One-clock pulse on the debounced press (1 -> 0).
    assign w_clr = r_db_prev & ~r_db_level;

    // ---------------- sticky errors ----------------
    logic [NUM_CH-1:0] r_sticky;

    // A set in the clear cycle survives because it is ORed in after the clear.
    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) r_sticky <= '0;
        else              r_sticky <= (w_clr ? '0 : r_sticky) | w_err;
    end

    assign sticky_err = r_sticky;

    // ---------------- LED / ready outputs ----------------
    logic       w_sel_valid;
    logic       w_sel_ready;
    logic       w_sel_lit;
    logic       w_sel_fail;
    logic       w_sel_sticky;
    logic [4:0] w_led_next;
    logic [4:0] r_user_led;
    logic       r_all_ready;

    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_ready  = 1'b0;
        w_sel_lit    = 1'b0;
        w_sel_fail   = 1'b0;
        w_sel_sticky = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 3'(i)) begin
                w_sel_valid  = 1'b1;
                w_sel_ready  = w_ready[i];
                w_sel_lit    = w_lit[i];
                w_sel_fail   = w_fail[i];
                w_sel_sticky = r_sticky[i];
            end
        end

        w_led_next    = 5'b11111;
        w_led_next[4] = r_hb[HB_BITS-1];
        w_led_next[3] = ~(|r_sticky);
        if (w_sel_valid) begin
            w_led_next[2] = ~w_sel_sticky;
            w_led_next[1] = w_sel_fail ? r_hb[BLINK_BIT] : ~w_sel_lit;
            w_led_next[0] = ~w_sel_ready;
        end
    end

    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) begin
            r_user_led  <= 5'b01111;
            r_all_ready <= 1'b0;
        end else begin
            r_user_led  <= w_led_next;
            r_all_ready <= &w_ready;
        end
    end

    assign user_led  = r_user_led;
    assign all_ready = r_all_ready;

endmodule

// File: tb/tb_emif_status_mon.sv
// Directed testbench for emif_status_mon with NUM_CH=2, HB_BITS=8,
// BLINK_BIT=4, DB_CYCLES=4, SYNC_STAGES=2. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so "after N ticks" means
// after the Nth rising edge following the stimulus change.
module tb_emif_status_mon;

    logic       clk_50_max10 = 1'b0;
    logic       fpga_resetn  = 1'b0;
    logic [1:0] init_done    = '0;
    logic [1:0] cal_success  = '0;
    logic [1:0] cal_fail     = '0;
    logic [1:0] error_mon    = '0;
    logic       pb_clr_n     = 1'b1;
    logic [2:0] ch_sel       = '0;
    logic [4:0] user_led;
    logic [1:0] sticky_err;
    logic       all_ready;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;   // rising edges since reset release = heartbeat value

    emif_status_mon #(
        .NUM_CH      (2),
        .HB_BITS     (8),
        .BLINK_BIT   (4),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .clk_50_max10 (clk_50_max10),
        .fpga_resetn  (fpga_resetn),
        .init_done    (init_done),
        .cal_success  (cal_success),
        .cal_fail     (cal_fail),
        .error_mon    (error_mon),
        .pb_clr_n     (pb_clr_n),
        .ch_sel       (ch_sel),
        .user_led     (user_led),
        .sticky_err   (sticky_err),
        .all_ready    (all_ready)
    );

    always #5 clk_50_max10 = ~clk_50_max10;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_50_max10);
            #1;
            if (!fpga_resetn) cyc = 0;
            else              cyc++;
        end
    endtask

    // LED value driven from heartbeat bit b as it stood before the last edge
    function automatic logic hb_bit_prev(input int b);
        return 1'(((cyc - 1) >> b) & 1);
    endfunction

    initial begin
        // ---- reset held, then released ----
        tick(3);
        check_eq("rst_led", user_led, 5'b01111);
        check_eq("rst_rdy", all_ready, 1'b0);
        check_eq("rst_sticky", sticky_err, 2'b00);
        fpga_resetn = 1'b1;
        tick(1);
        check_eq("post_rst_led", user_led, 5'b01111);
        check_eq("post_rst_rdy", all_ready, 1'b0);

        // ---- heartbeat MSB on LED4 toggles every 128 clocks ----
        while (cyc < 258) begin
            tick(1);
            if (cyc == 127 || cyc == 128 || cyc == 129 || cyc == 256 || cyc == 257)
                check_eq($sformatf("hb_led4_c%0d", cyc), user_led[4], hb_bit_prev(7));
        end

        // ---- ch0 calibrates then inits ----
        ch_sel      = 3'd0;
        cal_success = 2'b01;
        tick(4);
        check_eq("ch0_calok_led", user_led[1:0], 2'b01);
        init_done = 2'b01;
        tick(3);
        check_eq("ch0_ready_lat3", user_led[1:0], 2'b01);
        tick(1);
        check_eq("ch0_ready_lat4", user_led[1:0], 2'b00);
        check_eq("rdy_ch1_wait", all_ready, 1'b0);

        // ---- ch1 calibrates and inits together ----
        cal_success = 2'b11;
        init_done   = 2'b11;
        tick(4);
        check_eq("rdy_lat4", all_ready, 1'b0);
        tick(1);
        check_eq("rdy_lat5", all_ready, 1'b1);
        ch_sel = 3'd1;
        tick(1);
        check_eq("ch1_ready_led", user_led[1:0], 2'b00);

        // ---- ch1 recalibration drops it back to WAIT ----
        cal_success = 2'b01;
        tick(3);
        check_eq("recal_rdy_lat3", all_ready, 1'b1);
        tick(1);
        check_eq("recal_rdy_lat4", all_ready, 1'b0);
        check_eq("recal_led", user_led[1:0], 2'b11);

        // ---- ch1 cal_fail and cal_success in the same cycle -> FAIL ----
        cal_fail    = 2'b10;
        cal_success = 2'b11;
        tick(1);
        cal_fail    = 2'b00;
        cal_success = 2'b01;
        tick(3);
        for (int k = 0; k < 40; k++) begin
            tick(1);
            check_eq($sformatf("fail_blink_c%0d", cyc), user_led[1:0], {hb_bit_prev(4), 1'b1});
        end
        check_eq("fail_rdy", all_ready, 1'b0);

        // ---- sticky error on ch0 ----
        ch_sel    = 3'd0;
        error_mon = 2'b01;
        tick(1);
        error_mon = 2'b00;
        tick(1);
        check_eq("sticky_lat2", sticky_err, 2'b00);
        tick(1);
        check_eq("sticky_lat3", sticky_err, 2'b01);
        tick(1);
        check_eq("sticky_led", user_led[3:0], 4'b0000);

        // ---- bouncing button, lows never 4 clocks long -> no clear ----
        pb_clr_n = 1'b0; tick(3);
        pb_clr_n = 1'b1; tick(2);
        pb_clr_n = 1'b0; tick(2);
        pb_clr_n = 1'b1; tick(10);
        check_eq("bounce_noclr", sticky_err, 2'b01);

        // ---- 6-clock press clears after 2+4+1 clocks ----
        pb_clr_n = 1'b0;
        tick(6);
        pb_clr_n = 1'b1;
        check_eq("press_lat6", sticky_err, 2'b01);
        tick(1);
        check_eq("press_lat7", sticky_err, 2'b00);
        tick(1);
        check_eq("press_led", user_led[3:2], 2'b11);
        tick(10);

        // ---- error held through the clear pulse -> stays set ----
        error_mon = 2'b01;
        tick(3);
        pb_clr_n = 1'b0;
        tick(6);
        pb_clr_n = 1'b1;
        tick(1);
        check_eq("set_wins_clr", sticky_err, 2'b01);
        tick(2);
        check_eq("set_wins_after", sticky_err, 2'b01);
        error_mon = 2'b00;
        tick(5);
        check_eq("sticky_hold", sticky_err, 2'b01);
        tick(10);

        // ---- out-of-range channel select ----
        ch_sel = 3'd5;
        tick(1);
        check_eq("sel5_led", user_led[3:0], 4'b0111);

        // ---- reset in the middle of a debounce ----
        cal_success = 2'b00;
        init_done   = 2'b00;
        pb_clr_n    = 1'b0;
        tick(4);
        #2;
        fpga_resetn = 1'b0;
        #1;
        check_eq("arst_led", user_led, 5'b01111);
        check_eq("arst_rdy", all_ready, 1'b0);
        check_eq("arst_sticky", sticky_err, 2'b00);
        ch_sel = 3'd1;
        tick(3);
        fpga_resetn = 1'b1;
        // button still held: a full 2+4 clock debounce must restart from here
        error_mon = 2'b01;
        tick(1);
        error_mon = 2'b00;
        check_eq("rel_led", user_led, 5'b01111);
        tick(2);
        check_eq("rel_sticky_e3", sticky_err, 2'b01);
        tick(1);
        check_eq("rel_sticky_e4", sticky_err, 2'b01);
        tick(1);
        check_eq("rel_sticky_e5", sticky_err, 2'b01);
        tick(1);
        check_eq("rel_sticky_e6", sticky_err, 2'b01);
        tick(1);
        check_eq("rel_sticky_e7", sticky_err, 2'b00);
        pb_clr_n = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
